// File: rtl/instr_fetch_if.sv
// Bundle of fetch-stage handshakes: instruction-memory request/response,
// execute-path redirect and the decoded-instruction output port.
//   master : the fetch stage (drives requests and the output port)
//   slave  : the environment (memory, execute path, downstream consumer)
interface instr_fetch_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_op;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output out_valid, out_instr, out_pc, out_op, out_funct3, out_funct7,
    input  out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  out_valid, out_instr, out_pc, out_op, out_funct3, out_funct7,
    output out_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage. Owns the PC, issues word requests to instruction
// memory under a credit limit, buffers returned words with their PCs in an
// in-order FIFO and presents the head pre-split into op/funct3/funct7.
// A redirect flushes the FIFO and marks every in-flight fetch as stale.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - instr_fetch_if.master: imem_req_*, imem_rsp_*, redirect_*, out_*
//
// state | meaning
// RUN   | no stale fetches outstanding, requests may issue
// DRAIN | waiting for stale responses (drop_cnt>0), no requests issue
module instr_fetch #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input logic         clk,
  input logic         rst,
  instr_fetch_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   count;
  logic [CW-1:0]   drop_cnt;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [XLEN-1:0] buf_instr [FIFO_DEPTH];
  logic [XLEN-1:0] buf_pc    [FIFO_DEPTH];
  // PCs of issued requests, consumed one per response (stale or not)
  logic [XLEN-1:0] pcq       [FIFO_DEPTH];
  logic [AW-1:0]   pcq_rd, pcq_wr;

  logic          pop, accept, rsp, push;
  logic [CW:0]   credit_used;
  logic [CW-1:0] drop_on_redirect;

  assign rsp    = bus.imem_rsp_valid;
  assign pop    = bus.out_valid & bus.out_ready;
  assign accept = bus.imem_req_valid & bus.imem_req_ready;
  assign push   = rsp && !bus.redirect_valid && (drop_cnt == '0);

  // A slot freed by this cycle's pop may be re-requested immediately, which
  // is what sustains one instruction per cycle at latency 1.
  assign credit_used = (CW+1)'(outstanding) + (CW+1)'(count) - (CW+1)'(pop);
  // A response arriving together with the redirect is already discarded,
  // so it does not count as a future stale response.
  assign drop_on_redirect = outstanding - CW'(rsp);

  assign bus.imem_req_valid = !rst && !bus.redirect_valid && (state == RUN) &&
                              (credit_used < (CW+1)'(FIFO_DEPTH));
  assign bus.imem_req_addr  = pc;

  assign bus.out_valid  = !rst && (count != '0);
  assign bus.out_instr  = rst ? '0 : buf_instr[rd_ptr];
  assign bus.out_pc     = rst ? '0 : buf_pc[rd_ptr];
  assign bus.out_op     = bus.out_instr[6:0];
  assign bus.out_funct3 = bus.out_instr[14:12];
  assign bus.out_funct7 = bus.out_instr[31:25];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      outstanding <= '0;
      count       <= '0;
      drop_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      pcq_rd      <= '0;
      pcq_wr      <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(rsp);
      if (accept) begin
        pcq[pcq_wr] <= pc;
        pcq_wr      <= pcq_wr + AW'(1);
      end
      if (rsp) pcq_rd <= pcq_rd + AW'(1);

      if (bus.redirect_valid) begin
        pc       <= bus.redirect_pc & ~XLEN'(3);
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        drop_cnt <= drop_on_redirect;
        state    <= (drop_on_redirect != '0) ? DRAIN : RUN;
      end else begin
        if (accept) pc <= pc + XLEN'(4);
        if (rsp && drop_cnt != '0) begin
          drop_cnt <= drop_cnt - CW'(1);
          if (drop_cnt == CW'(1)) state <= RUN;
        end
        if (push) begin
          buf_instr[wr_ptr] <= bus.imem_rsp_data;
          buf_pc[wr_ptr]    <= pcq[pcq_rd];
          wr_ptr            <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // The credit limit makes these unreachable; tripping one means a logic bug.
  always @(posedge clk) begin
    if (!rst && push && !pop) assert (count != CW'(FIFO_DEPTH));
    if (!rst && rsp) assert (outstanding != '0);
  end
endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if #(.XLEN(32)) bus ();
  instr_fetch #(.XLEN(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct { int due; logic [31:0] addr; int ep; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] exp_addr; int lat; } vec_t;

  req_t q[$];
  int n_cmp = 0, n_err = 0;
  int cyc = 0, last_due = 0, lat = 1, p_rr = 100, p_or = 100;
  int ep = 0, buffered = 0, rsp_ep = 0;
  logic rsp_now = 0;
  logic redir_v = 0;
  logic [31:0] redir_pc = '0;
  logic [31:0] exp_req = RESET_PC, exp_out = RESET_PC;
  logic hold = 0;
  logic [31:0] hold_pc, hold_instr;
  logic last_acc, last_pop;
  logic [31:0] last_acc_addr, last_pop_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0101_0101) ^ 32'h5A3C_0F96 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endtask

  // Sampled at negedge: checks the cycle's events against the stream model.
  task automatic sample();
    logic acc, pop, rdr;
    logic [31:0] ew, t;
    acc = bus.imem_req_valid && bus.imem_req_ready;
    pop = bus.out_valid && bus.out_ready;
    rdr = bus.redirect_valid;
    last_acc = acc; last_acc_addr = bus.imem_req_addr;
    last_pop = pop; last_pop_pc = bus.out_pc;
    if (rst) begin
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_req_valid", bus.imem_req_valid, 0);
      chk("rst_out_pc", bus.out_pc, 0);
      chk("rst_out_instr", bus.out_instr, 0);
      q.delete();
      buffered = 0; ep++; last_due = cyc;
      exp_req = RESET_PC; exp_out = RESET_PC; hold = 0;
      return;
    end
    if (hold) begin
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_pc", bus.out_pc, hold_pc);
      chk("hold_instr", bus.out_instr, hold_instr);
    end
    if (rdr) chk("redir_no_req", bus.imem_req_valid, 0);
    if (acc) begin
      req_t r;
      chk("req_addr", bus.imem_req_addr, exp_req);
      r.due = cyc + lat;
      if (r.due <= last_due) r.due = last_due + 1;
      last_due = r.due;
      r.addr = bus.imem_req_addr; r.ep = ep;
      q.push_back(r);
      exp_req += 32'd4;
    end
    if (rsp_now && rsp_ep == ep && !rdr) buffered++;
    if (pop) begin
      ew = mem_word(exp_out);
      chk("out_pc", bus.out_pc, exp_out);
      chk("out_instr", bus.out_instr, ew);
      chk("out_op", 32'(bus.out_op), 32'(ew[6:0]));
      chk("out_funct3", 32'(bus.out_funct3), 32'(ew[14:12]));
      chk("out_funct7", 32'(bus.out_funct7), 32'(ew[31:25]));
      exp_out += 32'd4;
      buffered--;
    end
    if (rdr) begin
      t = redir_pc & ~32'd3;
      exp_req = t; exp_out = t; ep++; buffered = 0;
    end
    chk("credit_limit", 32'(q.size() + buffered <= DEPTH), 1);
    hold = bus.out_valid && !bus.out_ready && !rdr;
    hold_pc = bus.out_pc; hold_instr = bus.out_instr;
  endtask

  // Called just after a posedge; drives the cycle, samples, advances.
  task automatic cycle();
    bus.redirect_valid = redir_v && !rst;
    bus.redirect_pc    = redir_pc;
    bus.imem_req_ready = ($urandom_range(99) < p_rr);
    bus.out_ready      = ($urandom_range(99) < p_or);
    rsp_now = 0;
    bus.imem_rsp_data = $urandom;
    if (!rst && q.size() > 0 && q[0].due <= cyc) begin
      rsp_now = 1;
      rsp_ep = q[0].ep;
      bus.imem_rsp_data = mem_word(q[0].addr);
      void'(q.pop_front());
    end
    bus.imem_rsp_valid = rsp_now;
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_inflight(input int n, input string nm);
    int k;
    for (k = 0; k < 40 && q.size() < n; k++) cycle();
    if (k == 40) timeout(nm);
  endtask

  vec_t vecs[5];

  initial begin
    int first_pop, n_pops, got, k;
    logic [31:0] wrap_addrs[3];
    vecs[0] = '{32'h0000_0103, 32'h0000_0100, 3};
    vecs[1] = '{32'h1234_5679, 32'h1234_5678, 2};
    vecs[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 1};
    vecs[3] = '{32'h0000_0002, 32'h0000_0000, 2};
    vecs[4] = '{32'h8000_0FF1, 32'h8000_0FF0, 4};

    bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = '0;
    bus.redirect_valid = 0; bus.redirect_pc = '0; bus.out_ready = 0;
    @(posedge clk); #1;
    repeat (3) cycle();
    rst = 0;

    // Fill latency and steady throughput
    first_pop = -1; n_pops = 0;
    for (int i = 0; i < 22; i++) begin
      cycle();
      if (i == 0) chk("first_req_after_reset", 32'(last_acc), 1);
      if (last_pop) begin
        n_pops++;
        if (first_pop < 0) first_pop = i;
      end
    end
    chk("fill_latency", first_pop, 2);
    chk("throughput", n_pops, 20);

    // Consumer stall
    p_or = 0;
    repeat (10) cycle();
    chk("stall_buffered", buffered, DEPTH);
    chk("stall_out_valid", 32'(bus.out_valid), 1);
    p_or = 100;
    repeat (10) cycle();

    // Redirect vectors
    foreach (vecs[v]) begin
      lat = vecs[v].lat;
      wait_inflight((lat > 1) ? 2 : 1, "vec_inflight_wait");
      redir_v = 1; redir_pc = vecs[v].pc;
      cycle();
      redir_v = 0;
      got = 0;
      for (k = 0; k < 40; k++) begin
        cycle();
        if (last_acc && !got) begin
          got = 1;
          chk("vec_first_req", last_acc_addr, vecs[v].exp_addr);
        end
        if (last_pop) begin
          chk("vec_first_out_pc", last_pop_pc, vecs[v].exp_addr);
          break;
        end
      end
      if (k == 40) timeout("vec_first_out");
    end

    // PC wrap
    lat = 1;
    redir_v = 1; redir_pc = 32'hFFFF_FFF8;
    cycle();
    redir_v = 0;
    got = 0;
    for (k = 0; k < 40 && got < 3; k++) begin
      cycle();
      if (last_acc) begin wrap_addrs[got] = last_acc_addr; got++; end
    end
    if (got < 3) timeout("wrap_wait");
    else begin
      chk("wrap_addr0", wrap_addrs[0], 32'hFFFF_FFF8);
      chk("wrap_addr1", wrap_addrs[1], 32'hFFFF_FFFC);
      chk("wrap_addr2", wrap_addrs[2], 32'h0000_0000);
    end

    // Redirect coinciding with a response and a pop
    lat = 2;
    for (k = 0; k < 40; k++) begin
      if (bus.out_valid && q.size() > 0 && q[0].due <= cyc) break;
      cycle();
    end
    if (k == 40) timeout("coincide_wait");
    else begin
      redir_v = 1; redir_pc = 32'h0000_0400;
      cycle();
      redir_v = 0;
      chk("coincide_popped", 32'(last_pop), 1);
      chk("coincide_flushed", 32'(bus.out_valid), 0);
      repeat (15) cycle();
    end

    // Reset mid-stream with fetches in flight
    lat = 3;
    wait_inflight(2, "reset_inflight_wait");
    rst = 1;
    cycle();
    rst = 0;
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    for (k = 0; k < 40; k++) begin
      cycle();
      if (last_pop) begin
        chk("reset_first_out_pc", last_pop_pc, RESET_PC);
        break;
      end
    end
    if (k == 40) timeout("reset_first_out");

    // Randomized traffic against the stream model
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        lat  = $urandom_range(4, 1);
        p_rr = $urandom_range(100, 40);
        p_or = $urandom_range(100, 30);
      end
      redir_v = ($urandom_range(99) < 3);
      redir_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      rst = ($urandom_range(999) < 3);
      cycle();
    end
    redir_v = 0; rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
